data_io_sync: RTL and testbench

//  Parametrised download client for the io controller SPI link. Oversamples sck/ss/sdi in the

---
 rtl/data_io_sync.sv | 250 +++++++++++++++++++++++++
 tb/tb_data_io_sync.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_sync.sv
// data_io_sync: SPI download client with byte FIFO, handshaked RAM write port and erase engine.
// Optional feature macro DATA_IO_CHECKSUM_EN builds a 16-bit sum of data bytes written to RAM.
module data_io_sync #(
    parameter int unsigned         AW         = 25,
    parameter int unsigned         IDX_W      = 5,
    parameter int unsigned         N_MAP      = 4,
    parameter logic [N_MAP*AW-1:0] BASE_MAP   = {25'h600000, 25'h400000, 25'h200000, 25'h000000},
    parameter logic [AW-1:0]       DEF_BASE   = 25'h170000,
    parameter int unsigned         ERASE_IDX  = 0,
    parameter logic [AW-1:0]       ERASE_BASE = 25'h1a0000,
    parameter logic [AW-1:0]       ERASE_END  = 25'h1bffff,
    parameter int unsigned         ERASE_DIV  = 32,
    parameter int unsigned         FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck_i,
    input  logic             ss_i,
    input  logic             sdi_i,
    input  logic             force_erase_i,
    output logic             downloading_o,
    output logic             erasing_o,
    output logic [IDX_W-1:0] index_o,
    output logic             wr_o,
    input  logic             wr_ack_i,
    output logic [AW-1:0]    addr_o,
    output logic [7:0]       dout_o,
    output logic             overflow_o,
    output logic [15:0]      checksum_o
);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned DIVW = $clog2(ERASE_DIV + 1);
    localparam logic [7:0] CmdIndex = 8'h55;
    localparam logic [7:0] CmdTx    = 8'h53;
    localparam logic [7:0] CmdTxDat = 8'h54;

    typedef enum logic [1:0] {StIdle, StDataWr, StEraseWr, StEraseWait} state_e;

    logic [2:0]      sck_s_q;
    logic [1:0]      ss_s_q, sdi_s_q;
    logic            fe_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [6:0]      sr_q, sr_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            dl_q, dl_d, ovf_q, ovf_d, pend_q, pend_d;
    logic [PW:0]     wptr_q, rptr_q, count;
    logic [AW+7:0]   mem_q [FIFO_DEPTH];
    logic [AW+7:0]   head;
    state_e          state_q, state_d;
    logic [AW-1:0]   eaddr_q, eaddr_d;
    logic            erasing_q, erasing_d, restart_q, restart_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            sck_rise, ss_hi, fe_rise, empty, full;
    logic            arm, push, pop, tx_start, erase_start;
    logic [7:0]      rx_byte;

    function automatic logic [AW-1:0] map_base(input logic [IDX_W-1:0] idx);
        logic [AW-1:0] base;
        base = DEF_BASE;
        for (int unsigned i = 0; i < N_MAP; i++) begin
            if (32'(idx) == i) base = BASE_MAP[i*AW +: AW];
        end
        return base;
    endfunction

    assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
    assign ss_hi    = ss_s_q[1];
    assign rx_byte  = {sr_q, sdi_s_q[1]};
    assign fe_rise  = force_erase_i & ~fe_q;
    assign count    = wptr_q - rptr_q;
    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign head     = mem_q[rptr_q[PW-1:0]];

    // Serial deframing and command decode
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        cmd_d     = cmd_q;
        index_d   = index_q;
        waddr_d   = waddr_q;
        dl_d      = dl_q;
        ovf_d     = ovf_q;
        arm       = 1'b0;
        push      = 1'b0;
        tx_start  = 1'b0;
        if (ss_hi) begin
            bit_cnt_d = '0;
        end else if (sck_rise) begin
            sr_d      = rx_byte[6:0];
            bit_cnt_d = (bit_cnt_q == 4'd15) ? 4'd8 : bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) cmd_d = rx_byte;
            if (bit_cnt_q == 4'd15) begin
                case (cmd_q)
                    CmdIndex: index_d = rx_byte[IDX_W-1:0];
                    CmdTx: begin
                        if (rx_byte[0]) begin
                            tx_start = 1'b1;
                            waddr_d  = map_base(index_q);
                            dl_d     = 1'b1;
                            ovf_d    = 1'b0;
                        end else begin
                            dl_d = 1'b0;
                            arm  = (index_q == IDX_W'(ERASE_IDX));
                        end
                    end
                    CmdTxDat: begin
                        if (full) ovf_d = 1'b1;
                        else push = 1'b1;
                        waddr_d = waddr_q + AW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write port: data always drains before an erase may take the port
    always_comb begin
        state_d     = state_q;
        eaddr_d     = eaddr_q;
        erasing_d   = erasing_q;
        restart_d   = restart_q;
        pop         = 1'b0;
        erase_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StDataWr;
                end else if (pend_q && !dl_q) begin
                    erase_start = 1'b1;
                    state_d     = StEraseWr;
                    eaddr_d     = ERASE_BASE;
                    erasing_d   = 1'b1;
                    restart_d   = 1'b0;
                end
            end
            StDataWr: begin
                if (wr_ack_i) begin
                    pop = 1'b1;
                    if (!((count > (PW+1)'(1)) || push)) state_d = StIdle;
                end
            end
            StEraseWr: begin
                if (wr_ack_i) begin
                    if (restart_q || fe_rise) begin
                        eaddr_d   = ERASE_BASE;
                        restart_d = 1'b0;
                        state_d   = StEraseWait;
                    end else if (eaddr_q == ERASE_END) begin
                        erasing_d = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        eaddr_d = eaddr_q + AW'(1);
                        state_d = StEraseWait;
                    end
                end else if (fe_rise) begin
                    // address must stay stable while wr is high, so defer the restart
                    restart_d = 1'b1;
                end
            end
            StEraseWait: begin
                if (fe_rise) eaddr_d = ERASE_BASE;
                if (div_q >= DIVW'(ERASE_DIV - 1)) state_d = StEraseWr;
            end
            default: state_d = StIdle;
        endcase

        pend_d = pend_q;
        if (erase_start) pend_d = 1'b0;
        if (arm || (fe_rise && !erasing_q)) pend_d = 1'b1;

        // cycles since the last erase write start, saturating
        if (state_d == StEraseWr && state_q != StEraseWr) div_d = '0;
        else if (div_q < DIVW'(ERASE_DIV - 1)) div_d = div_q + DIVW'(1);
        else div_d = div_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s_q   <= '0;
            ss_s_q    <= '1;
            sdi_s_q   <= '0;
            fe_q      <= 1'b0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            cmd_q     <= '0;
            index_q   <= '0;
            waddr_q   <= '0;
            dl_q      <= 1'b0;
            ovf_q     <= 1'b0;
            pend_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            state_q   <= StIdle;
            eaddr_q   <= '0;
            erasing_q <= 1'b0;
            restart_q <= 1'b0;
            div_q     <= '0;
        end else begin
            sck_s_q   <= {sck_s_q[1:0], sck_i};
            ss_s_q    <= {ss_s_q[0], ss_i};
            sdi_s_q   <= {sdi_s_q[0], sdi_i};
            fe_q      <= force_erase_i;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            cmd_q     <= cmd_d;
            index_q   <= index_d;
            waddr_q   <= waddr_d;
            dl_q      <= dl_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            wptr_q    <= wptr_q + (PW+1)'(push);
            rptr_q    <= rptr_q + (PW+1)'(pop);
            state_q   <= state_d;
            eaddr_q   <= eaddr_d;
            erasing_q <= erasing_d;
            restart_q <= restart_d;
            div_q     <= div_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= {waddr_q, rx_byte};
    end

`ifdef DATA_IO_CHECKSUM_EN
    logic [15:0] csum_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else if (tx_start) csum_q <= '0;
        else if (pop) csum_q <= csum_q + {8'h00, head[7:0]};
    end
    assign checksum_o = csum_q;
`else
    assign checksum_o = 16'h0000;
`endif

    assign downloading_o = dl_q;
    assign erasing_o     = erasing_q;
    assign index_o       = index_q;
    assign overflow_o    = ovf_q;
    assign wr_o          = (state_q == StDataWr) || (state_q == StEraseWr);
    assign addr_o        = (state_q == StDataWr)  ? head[AW+7:8] :
                           (state_q == StEraseWr) ? eaddr_q : '0;
    assign dout_o        = (state_q == StDataWr) ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_data_io_sync.sv
// Bench for data_io_sync: random SPI downloads checked against a transaction-level model.
module tb_data_io_sync;
    localparam int unsigned   AW    = 25;
    localparam int unsigned   DEPTH = 4;
    localparam int unsigned   DIV   = 6;
    localparam logic [AW-1:0] EBASE = 25'h1a0000;
    localparam logic [AW-1:0] EEND  = 25'h1a0007;

    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, ss = 1'b1, sdi = 1'b0;
    logic force_erase = 1'b0, wr_ack = 1'b0;
    logic downloading, erasing, wr, overflow;
    logic [4:0] index;
    logic [AW-1:0] addr;
    logic [7:0] dout;
    logic [15:0] checksum;

    data_io_sync #(
        .AW(AW), .IDX_W(5), .N_MAP(4),
        .BASE_MAP({25'h600000, 25'h400000, 25'h200000, 25'h000000}),
        .DEF_BASE(25'h170000), .ERASE_IDX(0), .ERASE_BASE(EBASE), .ERASE_END(EEND),
        .ERASE_DIV(DIV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sck_i(sck), .ss_i(ss), .sdi_i(sdi),
        .force_erase_i(force_erase), .downloading_o(downloading), .erasing_o(erasing),
        .index_o(index), .wr_o(wr), .wr_ack_i(wr_ack), .addr_o(addr), .dout_o(dout),
        .overflow_o(overflow), .checksum_o(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    bit ack_en = 1'b1;
    int lat_min = 0, lat_max = 2, lat = 0, wait_n = 0;
    bit in_wr = 1'b0, cur_er = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    int cur_start = 0, addr_glitch = 0;
    logic [33:0] log_q[$], exp_q[$];
    int st_q[$];

    logic [4:0]    m_index = '0;
    logic [AW-1:0] m_waddr = '0;
    bit            m_dl = 1'b0, m_ovf = 1'b0;
    int            m_held = 0;
    logic [15:0]   m_csum = '0;
    logic [7:0]    pay_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // RAM side: random ack latency, logs each accepted write as {erasing, addr, data}
    always @(negedge clk) begin
        if (wr) begin
            if (!in_wr) begin
                in_wr = 1'b1; cur_addr = addr; cur_start = cyc; cur_er = erasing;
            end else if (addr !== cur_addr) begin
                addr_glitch++;
            end
            if (ack_en && wait_n >= lat) begin
                wr_ack = 1'b1;
                log_q.push_back({cur_er, addr, dout});
                st_q.push_back(cur_start);
                in_wr = 1'b0; wait_n = 0;
                lat = $urandom_range(lat_max, lat_min);
            end else begin
                wr_ack = 1'b0;
                if (ack_en) wait_n++;
            end
        end else begin
            wr_ack = 1'b0; in_wr = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] map_ref(input logic [4:0] idx);
        case (idx)
            5'd0: return 25'h000000;
            5'd1: return 25'h200000;
            5'd2: return 25'h400000;
            5'd3: return 25'h600000;
            default: return 25'h170000;
        endcase
    endfunction

    function automatic logic [15:0] exp_cs();
`ifdef DATA_IO_CHECKSUM_EN
        return m_csum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic spi_bit(input logic b);
        sck = 1'b0; sdi = b; repeat (4) @(negedge clk);
        sck = 1'b1; repeat (4) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame(input logic [7:0] cmd);
        ss = 1'b0; repeat (4) @(negedge clk);
        spi_byte(cmd);
        foreach (pay_q[i]) spi_byte(pay_q[i]);
        sck = 1'b0; repeat (4) @(negedge clk);
        ss = 1'b1; repeat (6) @(negedge clk);
    endtask

    task automatic do_index(input logic [7:0] v);
        pay_q = '{v};
        frame(8'h55);
        m_index = v[4:0];
    endtask

    task automatic add_erase();
        for (int k = 0; k <= int'(EEND - EBASE); k++) exp_q.push_back({1'b1, EBASE + AW'(k), 8'h00});
    endtask

    task automatic do_tx(input logic start);
        int r;
        r = $urandom();
        pay_q = '{{r[6:0], start}};
        frame(8'h53);
        if (start) begin
            m_waddr = map_ref(m_index); m_dl = 1'b1; m_ovf = 1'b0; m_csum = '0;
        end else begin
            m_dl = 1'b0;
            if (m_index == 5'd0) add_erase();
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!ack_en && m_held == int'(DEPTH)) begin
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back({1'b0, m_waddr, b});
            m_csum = m_csum + {8'h00, b};
            if (!ack_en) m_held++;
        end
        m_waddr = m_waddr + AW'(1);
    endtask

    task automatic do_data();
        frame(8'h54);
        foreach (pay_q[i]) model_byte(pay_q[i]);
    endtask

    task automatic rand_pay(input int n);
        int r;
        pay_q.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            pay_q.push_back(r[7:0]);
        end
    endtask

    task automatic check_writes(input string tag);
        int t;
        t = 0;
        while (log_q.size() < exp_q.size() && t < 4000) begin
            @(negedge clk); t++;
        end
        repeat (30) @(negedge clk);
        chk({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
        for (int i = 1; i < st_q.size(); i++)
            if (log_q[i][33] && log_q[i-1][33])
                chk($sformatf("%s_spacing%0d", tag, i), 64'(st_q[i] - st_q[i-1] >= DIV), 64'(1));
        chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, "_downloading"}, 64'(downloading), 64'(m_dl));
        chk({tag, "_erasing"}, 64'(erasing), 64'(0));
        chk({tag, "_checksum"}, 64'(checksum), 64'(exp_cs()));
        log_q.delete(); st_q.delete(); exp_q.delete();
    endtask

    initial begin
        int r, idx, t;
        repeat (3) @(negedge clk);
        chk("rst_wr", 64'(wr), 64'(0));
        chk("rst_erasing", 64'(erasing), 64'(0));
        chk("rst_downloading", 64'(downloading), 64'(0));
        chk("rst_index", 64'(index), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_addr", 64'(addr), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_checksum", 64'(checksum), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // index 2, three bytes, ack one cycle late; upper payload bits must be ignored
        lat_min = 1; lat_max = 1; lat = 1;
        r = $urandom();
        do_index({r[2:0], 5'd2});
        chk("index2", 64'(index), 64'(2));
        do_tx(1'b1);
        chk("tx_start_dl", 64'(downloading), 64'(1));
        chk("tx_start_ovf", 64'(overflow), 64'(0));
        pay_q = '{8'hA5, 8'h5A, 8'hFF};
        do_data();
        check_writes("map2");

        do_tx(1'b1);
        pay_q = '{8'h01, 8'h02, 8'hFF};
        do_data();
        check_writes("csum");
`ifdef DATA_IO_CHECKSUM_EN
        chk("csum_value", 64'(checksum), 64'h0102);
`else
        chk("csum_value", 64'(checksum), 64'h0000);
`endif
        do_tx(1'b0);
        chk("tx_end_dl", 64'(downloading), 64'(0));

        // unmapped index then random downloads
        lat_min = 0; lat_max = 2;
        do_index(8'd7);
        do_tx(1'b1);
        rand_pay(2);
        do_data();
        check_writes("unmapped");
        for (int it = 0; it < 4; it++) begin
            idx = $urandom_range(9, 1);
            do_index(8'(idx));
            chk($sformatf("rand%0d_index", it), 64'(index), 64'(idx));
            do_tx(1'b1);
            rand_pay($urandom_range(5, 1));
            do_data();
            do_tx(1'b0);
            check_writes($sformatf("rand%0d", it));
        end

        // partial byte after a full one is discarded and does not advance the address
        do_tx(1'b1);
        rand_pay(1);
        ss = 1'b0; repeat (4) @(negedge clk);
        spi_byte(8'h54);
        spi_byte(pay_q[0]);
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        sck = 1'b0; repeat (4) @(negedge clk);
        ss = 1'b1; repeat (6) @(negedge clk);
        model_byte(pay_q[0]);
        rand_pay(1);
        do_data();
        check_writes("partial");

        // overflow with RAM stalled
        ack_en = 1'b0; m_held = 0;
        do_tx(1'b1);
        rand_pay(DEPTH + 2);
        do_data();
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_no_acks", 64'(log_q.size()), 64'(0));
        ack_en = 1'b1; m_held = 0;
        check_writes("ovf");
        do_tx(1'b1);
        chk("ovf_cleared", 64'(overflow), 64'(0));

        // download on the erase index arms the erase engine
        lat_min = 0; lat_max = 1;
        do_index(8'd0);
        do_tx(1'b1);
        rand_pay(2);
        do_data();
        do_tx(1'b0);
        check_writes("erase");

        // forced erase, restarted after three writes
        lat_min = 0; lat_max = 0; lat = 0;
        @(negedge clk) force_erase = 1'b1;
        @(negedge clk) force_erase = 1'b0;
        t = 0;
        while (log_q.size() < 3 && t < 500) begin
            @(negedge clk); t++;
        end
        @(negedge clk) force_erase = 1'b1;
        @(negedge clk) force_erase = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, EBASE + AW'(k), 8'h00});
        add_erase();
        check_writes("restart");

        // asynchronous reset in the middle of an erase write
        ack_en = 1'b0;
        @(negedge clk) force_erase = 1'b1;
        @(negedge clk) force_erase = 1'b0;
        t = 0;
        while (!wr && t < 200) begin
            @(negedge clk); t++;
        end
        chk("pre_rst_erase_wr", 64'({wr, erasing}), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wr", 64'(wr), 64'(0));
        chk("async_rst_erasing", 64'(erasing), 64'(0));
        chk("async_rst_addr", 64'(addr), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete(); st_q.delete(); exp_q.delete();
        m_index = '0; m_waddr = '0; m_dl = 1'b0; m_ovf = 1'b0; m_csum = '0; m_held = 0;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_index", 64'(index), 64'(0));
        do_index(8'd1);
        do_tx(1'b1);
        rand_pay(2);
        do_data();
        check_writes("post_rst");

        chk("addr_stable", 64'(addr_glitch), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
